// File: rtl/alu_pkg.sv
// Shared opcode/funct3 constants and instruction field layout for the decoder and ALU.
// No logic and no latency; a constants-only package.
package alu_pkg;

  localparam int NREGS = 32;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    F3_ADD  = 3'd0,
    F3_SLL  = 3'd1,
    F3_SLT  = 3'd2,
    F3_SLTU = 3'd3,
    F3_XOR  = 3'd4,
    F3_SR   = 3'd5,
    F3_OR   = 3'd6,
    F3_AND  = 3'd7
  } funct3_e;

  // R-type view of the instruction word; the I-type immediate is {funct7, rs2}.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32-entry register file: two async read ports, one sync write port, x0 reads zero.
// Reads are combinational; a same-cycle write to the read address is bypassed.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0)              ? '0    :
                  (we && (waddr == raddr1))     ? wdata :
                                                  mem[raddr1];

  assign rdata2 = (raddr2 == 5'd0)              ? '0    :
                  (we && (waddr == raddr2))     ? wdata :
                                                  mem[raddr2];

endmodule

// File: rtl/alu_decode.sv
// RV32 ALU-op decoder with register read and busy-bit scoreboard; issue fields are a 1-cycle pulse.
// instr_ready drops combinationally on a source hazard; a same-cycle write-back lifts it.
module alu_decode
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] RS1,
  output logic [WIDTH-1:0] RS2,
  output logic [2:0]       Funct3,
  output logic [6:0]       Funct7,
  output logic [6:0]       opcode,
  output logic [11:0]      Imm_reg,
  output logic [4:0]       rd_addr,
  output logic             illegal
);

  rtype_t           dec;
  logic             legal;
  logic             is_reg;
  logic             hazard;
  logic             xfer;
  logic             issue;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] busy_live;
  logic [NREGS-1:0] busy_nxt;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;

  assign dec    = rtype_t'(instr);
  assign legal  = op_legal(dec.opcode);
  assign is_reg = (dec.opcode == OP_REG);

  always_comb begin
    wb_clr = '0;
    if (wb_en) wb_clr[wb_addr] = 1'b1;
  end

  // Busy view after this cycle's write-back, so a completing producer releases its reader now.
  assign busy_live = busy & ~wb_clr;

  assign hazard      = busy_live[dec.rs1] || (is_reg && busy_live[dec.rs2]);
  assign instr_ready = !(instr_valid && legal && hazard);
  assign xfer        = instr_valid && instr_ready;
  assign issue       = xfer && legal;

  // Set is applied after the clear so an issue to rd wins over a write-back to rd.
  always_comb begin
    busy_nxt = busy_live;
    if (issue && (dec.rd != 5'd0)) busy_nxt[dec.rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  alu_regfile #(
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (dec.rs1),
    .raddr2 (dec.rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      RS1       <= '0;
      RS2       <= '0;
      Funct3    <= '0;
      Funct7    <= '0;
      opcode    <= '0;
      Imm_reg   <= '0;
      rd_addr   <= '0;
    end else begin
      out_valid <= issue;
      illegal   <= xfer && !legal;
      if (issue) begin
        RS1     <= rs1_val;
        RS2     <= rs2_val;
        Funct3  <= dec.funct3;
        Funct7  <= is_reg ? dec.funct7 : 7'd0;
        opcode  <= dec.opcode;
        Imm_reg <= {dec.funct7, dec.rs2};
        rd_addr <= dec.rd;
      end else begin
        RS1     <= '0;
        RS2     <= '0;
        Funct3  <= '0;
        Funct7  <= '0;
        opcode  <= '0;
        Imm_reg <= '0;
        rd_addr <= '0;
      end
    end
  end

endmodule
